// File: rtl/register_window_controller_if.sv
// Bus between the register window controller, the register file and the backing-store memory.
// master: controller side; slave: control unit / register file / memory side.
interface register_window_controller_if #(
   parameter int unsigned NWIN     = 4,
   parameter int unsigned WIN_BITS = 2,
   parameter int unsigned DATA_W   = 32
);
   logic                    save;
   logic                    restore;
   logic                    wim_wr;
   logic [NWIN-1:0]         wim_in;
   logic [WIN_BITS-1:0]     cwp;
   logic [NWIN-1:0]         wim;
   logic                    busy;
   logic                    done;
   logic                    trap_ovf;
   logic                    trap_unf;
   logic [WIN_BITS-1:0]     rf_window;
   logic [4:0]              rf_pa;
   logic [DATA_W-1:0]       rf_pa_data;
   logic [4:0]              rf_pc;
   logic [DATA_W-1:0]       rf_wdata;
   logic                    rf_enable;
   logic                    rf_rw;
   logic [WIN_BITS+4-1:0]   mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_wr;
   logic                    mem_rd;
   logic                    mem_ready;
   logic [DATA_W-1:0]       mem_rdata;

   modport master (
      input  save, restore, wim_wr, wim_in, rf_pa_data, mem_ready, mem_rdata,
      output cwp, wim, busy, done, trap_ovf, trap_unf, rf_window, rf_pa, rf_pc,
             rf_wdata, rf_enable, rf_rw, mem_addr, mem_wdata, mem_wr, mem_rd
   );

   modport slave (
      output save, restore, wim_wr, wim_in, rf_pa_data, mem_ready, mem_rdata,
      input  cwp, wim, busy, done, trap_ovf, trap_unf, rf_window, rf_pa, rf_pc,
             rf_wdata, rf_enable, rf_rw, mem_addr, mem_wdata, mem_wr, mem_rd
   );
endinterface

// File: rtl/register_window_controller.sv
// Owns CWP/WIM for a 4-window register file; runs SAVE/RESTORE and the
// r16..r31 spill/fill sequences against the backing store on overflow/underflow.
module register_window_controller #(
   parameter int unsigned NWIN       = 4,
   parameter int unsigned WIN_BITS   = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SPILL_REGS = 16
) (
   input logic                          Clk,
   input logic                          Clr,
   register_window_controller_if.master bus
);
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned ADDR_W = WIN_BITS + IDX_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPILL_REGS - 1);
   localparam logic [4:0]       REG_BASE = 5'd16;
   localparam logic [NWIN-1:0]  WIM_RST  = NWIN'(2);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SPILL, ST_FILL_REQ, ST_FILL_WR, ST_FINISH
   } state_e;

   state_e              state_q, state_d;
   logic [WIN_BITS-1:0] cwp_q, cwp_d;
   logic [WIN_BITS-1:0] tgt_q, tgt_d;
   logic [NWIN-1:0]     wim_q, wim_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
   logic                rf_en_q, rf_en_d;
   logic [4:0]          rf_pa_q, rf_pa_d, rf_pc_q, rf_pc_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [WIN_BITS-1:0] rf_window_q, rf_window_d;

   logic [WIN_BITS-1:0] save_win, rest_win;
   logic                in_xfer;

   // State, architectural registers and registered outputs
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q     <= ST_IDLE;
         cwp_q       <= '0;
         tgt_q       <= '0;
         wim_q       <= WIM_RST;
         idx_q       <= '0;
         rf_wdata_q  <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         rf_en_q     <= 1'b0;
         rf_pa_q     <= '0;
         rf_pc_q     <= '0;
         mem_addr_q  <= '0;
         rf_window_q <= '0;
      end else begin
         state_q     <= state_d;
         cwp_q       <= cwp_d;
         tgt_q       <= tgt_d;
         wim_q       <= wim_d;
         idx_q       <= idx_d;
         rf_wdata_q  <= rf_wdata_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         rf_en_q     <= rf_en_d;
         rf_pa_q     <= rf_pa_d;
         rf_pc_q     <= rf_pc_d;
         mem_addr_q  <= mem_addr_d;
         rf_window_q <= rf_window_d;
      end
   end

   // Next-state logic; strobes are decoded from the next state so they register in step with it
   always_comb begin
      state_d    = state_q;
      cwp_d      = cwp_q;
      tgt_d      = tgt_q;
      wim_d      = wim_q;
      idx_d      = idx_q;
      rf_wdata_d = rf_wdata_q;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      save_win   = cwp_q - WIN_BITS'(1);
      rest_win   = cwp_q + WIN_BITS'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.wim_wr) begin
               wim_d = bus.wim_in;
            end else if (bus.save && !bus.restore) begin
               if (wim_q[save_win]) begin
                  tgt_d   = save_win;
                  idx_d   = '0;
                  ovf_d   = 1'b1;
                  state_d = ST_SPILL;
               end else begin
                  cwp_d   = save_win;
                  state_d = ST_FINISH;
               end
            end else if (bus.restore && !bus.save) begin
               if (wim_q[rest_win]) begin
                  tgt_d   = rest_win;
                  idx_d   = '0;
                  unf_d   = 1'b1;
                  state_d = ST_FILL_REQ;
               end else begin
                  cwp_d   = rest_win;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_SPILL: begin
            if (bus.mem_ready) begin
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  wim_d   = {wim_q[0], wim_q[NWIN-1:1]};
                  cwp_d   = tgt_q;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FILL_REQ: begin
            if (bus.mem_ready) begin
               rf_wdata_d = bus.mem_rdata;
               state_d    = ST_FILL_WR;
            end
         end
         ST_FILL_WR: begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               wim_d   = {wim_q[NWIN-2:0], wim_q[NWIN-1]};
               cwp_d   = tgt_q;
               state_d = ST_FINISH;
            end else begin
               state_d = ST_FILL_REQ;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_FINISH);
      mem_wr_d    = (state_d == ST_SPILL);
      mem_rd_d    = (state_d == ST_FILL_REQ);
      rf_en_d     = (state_d == ST_FILL_WR);
      in_xfer     = mem_wr_d || mem_rd_d || rf_en_d;
      rf_window_d = in_xfer ? tgt_d : cwp_d;
      rf_pa_d     = mem_wr_d ? (REG_BASE + 5'(idx_d)) : 5'd0;
      rf_pc_d     = rf_en_d  ? (REG_BASE + 5'(idx_d)) : 5'd0;
      mem_addr_d  = (mem_wr_d || mem_rd_d) ? {tgt_d, idx_d} : '0;
   end

   assign bus.cwp       = cwp_q;
   assign bus.wim       = wim_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.trap_ovf  = ovf_q;
   assign bus.trap_unf  = unf_q;
   assign bus.rf_window = rf_window_q;
   assign bus.rf_pa     = rf_pa_q;
   assign bus.rf_pc     = rf_pc_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.rf_enable = rf_en_q;
   assign bus.rf_rw     = rf_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_rd    = mem_rd_q;
   // Spill data is the register file's combinational read of rf_pa
   assign bus.mem_wdata = bus.rf_pa_data;

endmodule

// File: doc/register_window_controller.md
Name: register_window_controller

Overview:
- Sequencer that owns the current window pointer (CWP) and window invalid mask (WIM) for the 4-window register_file, and drives its current_window, read and write ports.
- Executes SAVE/RESTORE requests.
- On window overflow, spills the invalid window's locals and ins (r16..r31) to a backing store.
- On window underflow, fills that window back from the backing store.
- Sits between the control unit and register_file/memory interface.

Parameters:
NWIN, 4, number of register windows
WIN_BITS, 2, log2(NWIN)
DATA_W, 32, register/memory data width
SPILL_REGS, 16, registers moved per spill/fill (r16..r31)

Ports:
Clk  in  1  clock, all state on rising edge
Clr  in  1  synchronous active-high reset
save  in  1  SAVE request, sampled in IDLE only
restore  in  1  RESTORE request, sampled in IDLE only
wim_wr  in  1  load WIM from wim_in, IDLE only
wim_in  in  NWIN  new WIM value
cwp  out  WIN_BITS  current window pointer
wim  out  NWIN  window invalid mask
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse when a SAVE/RESTORE completes
trap_ovf  out  1  one-cycle pulse on entering SPILL
trap_unf  out  1  one-cycle pulse on entering FILL_REQ
rf_window  out  WIN_BITS  current_window to register_file
rf_pa  out  5  port A read address
rf_pa_data  in  DATA_W  port A data, combinational from register_file
rf_pc  out  5  port C write address
rf_wdata  out  DATA_W  write data to register_file
rf_enable  out  1  register_file write enable
rf_rw  out  1  1 = write
mem_addr  out  WIN_BITS+4  {window, idx[3:0]}, word address
mem_wdata  out  DATA_W  spill data
mem_wr  out  1  spill write request
mem_rd  out  1  fill read request
mem_ready  in  1  memory accepts write / returns read data this cycle
mem_rdata  in  DATA_W  fill data, valid when mem_rd and mem_ready

Behaviour:
- Reset (Clr=1 at edge, any state, including mid-spill/fill):
  - state=IDLE, cwp=0, wim=4'b0010, idx=0.
  - busy, done, traps, rf_enable, rf_rw, mem_wr, mem_rd all 0 in the following cycle.
  - rf_pa=rf_pc=0, rf_wdata=0.
  - No partial-transfer recovery.
- States: IDLE, SPILL, FILL_REQ, FILL_WR, FINISH.
- IDLE priority:
  - wim_wr loads wim and ignores save/restore that cycle.
  - save&restore both high: no-op, no done.
  - Otherwise act on save or restore.
- rf_window = cwp in IDLE/FINISH, and = target window in SPILL/FILL states.
- SAVE: new=(cwp-1) mod NWIN.
  - wim[new]=0: cwp<=new, go FINISH.
  - wim[new]=1: target<=new, idx<=0, go SPILL, trap_ovf pulse.
- RESTORE: new=(cwp+1) mod NWIN.
  - wim[new]=0: cwp<=new, go FINISH.
  - wim[new]=1: target<=new, idx<=0, go FILL_REQ, trap_unf pulse.
- SPILL:
  - rf_pa=16+idx, mem_wdata=rf_pa_data, mem_addr={target,idx}, mem_wr=1.
  - Hold all of these until mem_ready.
  - On an edge with mem_ready: idx++. If idx==15: wim<=rotate-right(wim) (bit i→bit i-1, bit0→bit NWIN-1), cwp<=target, go FINISH.
- FILL_REQ:
  - mem_rd=1, mem_addr={target,idx}, held until mem_ready.
  - On mem_ready: rf_wdata<=mem_rdata, go FILL_WR.
- FILL_WR:
  - One cycle: rf_enable=1, rf_rw=1, rf_pc=16+idx.
  - idx++. If idx==15: wim<=rotate-left(wim), cwp<=target, go FINISH. Else go FILL_REQ.
- FINISH: done=1 for one cycle, busy=1, then IDLE.
- Latency:
  - Non-trap request: cwp updates at the accepting edge, done in the next cycle.
  - Spill: 16 + (stall cycles) + 1 cycles.
  - Fill: minimum 2 per word + 1.
- Requests and wim_wr while busy are ignored and not queued.
- mem_wr and mem_rd are never high together. rf_enable is never high outside FILL_WR.

Test Plan:
1. Assert Clr for 2 cycles -> cwp=0, wim=4'b0010, busy=0, all strobes 0.
2. Three save pulses with mem_ready=1:
   - Saves 1 and 2 give cwp 3 then 2, each with done one cycle later and no trap.
   - Save 3 gives trap_ovf. mem_addr steps 16..31 on consecutive cycles, rf_pa steps 16..31, and mem_wdata equals register_file contents.
   - Afterwards cwp=1, wim=4'b0001, done pulses once.
3. Scenario 2, then hold mem_ready=0 for 3 cycles at idx=5 -> mem_wr, mem_addr=21 and mem_wdata stay stable. After release, exactly 16 writes total, no duplicates.
4. At cwp=1, wim_wr with wim_in=4'b0100, then restore with mem_rdata=0xA0+idx:
   - trap_unf fires; mem_addr runs 32..47.
   - rf_pc runs 16..31 with rf_enable one cycle each, and window 2 r16..r31 read back 0xA0..0xAF.
   - Afterwards cwp=2, wim=4'b1000.
5. Clr asserted at idx=7 of a spill -> next cycle IDLE, mem_wr=0, cwp=0, wim=4'b0010, no done.
6. save and restore high together in IDLE -> cwp/wim unchanged, done=0. save while busy -> ignored, single done at end.
